// File: rtl/mercury2_dac_receiver.sv
// Receiving end of the Mercury2 dual 10-bit SPI DAC link: oversampled SPI decode,
// per-channel input/output registers with LDAC transfer, and a settling-time model.
module mercury2_dac_receiver #(
  parameter int  ClockFreq    = 50_000_000,
  parameter real SettlingTime = 4.5e-6
) (
  input  logic       clk_50MHZ,
  input  logic       reset,
  input  logic       dac_csn,
  input  logic       dac_sdi,
  input  logic       dac_sck,
  input  logic       dac_ldac,
  output logic [9:0] chanA,
  output logic [9:0] chanB,
  output logic       gainA,
  output logic       gainB,
  output logic       activeA,
  output logic       activeB,
  output logic       frame_done,
  output logic       frame_chan,
  output logic       frame_error,
  output logic       settled
);

  localparam int         SettleClocks = int'(real'(ClockFreq) * SettlingTime);
  localparam logic [9:0] SettleLoad   = 10'(SettleClocks);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [2:0]  csn_sy, sck_sy, sdi_sy;
  logic [1:0]  ldac_sy;
  logic        csn_fall_p0, csn_rise_p0, sck_rise_p0;
  state_t      state;
  logic [15:0] shreg;
  logic [4:0]  bit_cnt;
  // Channel registers are packed as {active, gain, data[9:0]}.
  logic [11:0] in_a, in_b, in_a_next, in_b_next;
  logic [11:0] out_a, out_b, out_a_next, out_b_next;
  logic [11:0] frame_word;
  logic [9:0]  settle_cnt, settle_next;
  logic        frame_ok, frame_bad, out_change;

  // Stage: input synchronizers, preset to the idle bus levels
  always_ff @(posedge clk_50MHZ or posedge reset) begin
    if (reset) begin
      csn_sy  <= 3'b111;
      sck_sy  <= 3'b000;
      sdi_sy  <= 3'b000;
      ldac_sy <= 2'b11;
    end else begin
      csn_sy  <= {csn_sy[1:0], dac_csn};
      sck_sy  <= {sck_sy[1:0], dac_sck};
      sdi_sy  <= {sdi_sy[1:0], dac_sdi};
      ldac_sy <= {ldac_sy[0], dac_ldac};
    end
  end

  // Stage p0: registered edge flags; sdi_sy[2] lines up with sck_rise_p0
  always_ff @(posedge clk_50MHZ or posedge reset) begin
    if (reset) begin
      csn_fall_p0 <= 1'b0;
      csn_rise_p0 <= 1'b0;
      sck_rise_p0 <= 1'b0;
    end else begin
      csn_fall_p0 <= csn_sy[2] & ~csn_sy[1];
      csn_rise_p0 <= ~csn_sy[2] & csn_sy[1];
      sck_rise_p0 <= ~sck_sy[2] & sck_sy[1];
    end
  end

  always_comb begin
    frame_ok   = (state == SHIFT) && csn_rise_p0 && (bit_cnt == 5'd16);
    frame_bad  = (state == SHIFT) && csn_rise_p0 && (bit_cnt != 5'd16);
    frame_word = {shreg[12], shreg[13], shreg[11:2]};
    in_a_next  = in_a;
    in_b_next  = in_b;
    if (frame_ok) begin
      if (shreg[15]) in_b_next = frame_word;
      else           in_a_next = frame_word;
    end
    // A frame landing while LDAC is low goes straight through in the same update.
    out_a_next = out_a;
    out_b_next = out_b;
    if (!ldac_sy[1]) begin
      out_a_next = in_a_next;
      out_b_next = in_b_next;
    end
    out_change  = (out_a_next != out_a) || (out_b_next != out_b);
    settle_next = settle_cnt;
    if (out_change)             settle_next = SettleLoad;
    else if (settle_cnt != '0)  settle_next = settle_cnt - 10'd1;
  end

  // Stage p1: frame FSM, channel registers and settle counter
  always_ff @(posedge clk_50MHZ or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_chan  <= 1'b0;
      in_a        <= 12'h400;
      in_b        <= 12'h400;
      out_a       <= 12'h400;
      out_b       <= 12'h400;
      settle_cnt  <= '0;
      settled     <= 1'b1;
    end else begin
      if (csn_fall_p0) begin
        state   <= SHIFT;
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        if (csn_rise_p0) begin
          state <= IDLE;
        end else if (sck_rise_p0) begin
          shreg <= {shreg[14:0], sdi_sy[2]};
          if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
        end
      end
      frame_done  <= frame_ok;
      frame_error <= frame_bad;
      if (frame_ok) frame_chan <= shreg[15];
      in_a       <= in_a_next;
      in_b       <= in_b_next;
      out_a      <= out_a_next;
      out_b      <= out_b_next;
      settle_cnt <= settle_next;
      settled    <= (settle_next == '0);
    end
  end

  assign {activeA, gainA, chanA} = out_a;
  assign {activeB, gainB, chanB} = out_b;

endmodule

// File: tb/tb_mercury2_dac_receiver.sv
// Bench for mercury2_dac_receiver: directed vector table, hand-written timing
// sequences, and randomized frames against a register-level reference model.
module tb_mercury2_dac_receiver;

  logic       clk_50MHZ = 1'b0;
  logic       reset, dac_csn, dac_sdi, dac_sck, dac_ldac;
  logic [9:0] chanA, chanB;
  logic       gainA, gainB, activeA, activeB;
  logic       frame_done, frame_chan, frame_error, settled;

  mercury2_dac_receiver dut (
    .clk_50MHZ  (clk_50MHZ),
    .reset      (reset),
    .dac_csn    (dac_csn),
    .dac_sdi    (dac_sdi),
    .dac_sck    (dac_sck),
    .dac_ldac   (dac_ldac),
    .chanA      (chanA),
    .chanB      (chanB),
    .gainA      (gainA),
    .gainB      (gainB),
    .activeA    (activeA),
    .activeB    (activeB),
    .frame_done (frame_done),
    .frame_chan (frame_chan),
    .frame_error(frame_error),
    .settled    (settled)
  );

  always #10 clk_50MHZ = ~clk_50MHZ;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0, err_seen = 0, low_seen = 0;

  always @(negedge clk_50MHZ) begin
    if (frame_done)  done_seen++;
    if (frame_error) err_seen++;
    if (!settled)    low_seen++;
  end

  typedef struct {
    logic [31:0] word;
    int          nbits;
    int          ph;
    int          exp_done;
    int          exp_err;
    int          exp_chan;
    int          exp_a;
    int          exp_b;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50MHZ);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int reg_a();
    return int'({activeA, gainA, chanA});
  endfunction

  function automatic int reg_b();
    return int'({activeB, gainB, chanB});
  endfunction

  task automatic send_bits(input logic [31:0] w, input int n, input int ph);
    dac_csn = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      dac_sdi = w[i];
      tick(ph);
      dac_sck = 1'b1;
      tick(ph);
      dac_sck = 1'b0;
    end
    tick(ph);
  endtask

  task automatic send_frame(input logic [31:0] w, input int n, input int ph);
    send_bits(w, n, ph);
    dac_csn = 1'b1;
    tick(8);
  endtask

  // Reference model: abstract register file updated per whole frame / LDAC event.
  int in_m[2];
  int out_m[2];
  int last_chan;

  initial begin
    #50_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, e0, l0;
    logic [31:0] w;
    int n, mode, ph, r, ch, val;

    reset = 1'b1; dac_csn = 1'b1; dac_sck = 1'b0; dac_sdi = 1'b0; dac_ldac = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
    check("rst_chanA", reg_a(), 'h400);
    check("rst_chanB", reg_b(), 'h400);
    check("rst_settled", int'(settled), 1);
    check("rst_frame_chan", int'(frame_chan), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_error", int'(frame_error), 0);

    // Frame into A with LDAC high, then a 4-cycle LDAC pulse.
    d0 = done_seen;
    send_frame(32'h32AC, 16, 4);
    check("t1_done", done_seen - d0, 1);
    check("t1_chan", int'(frame_chan), 0);
    check("t1_hold_A", reg_a(), 'h400);
    l0 = low_seen;
    dac_ldac = 1'b0;
    tick(4);
    dac_ldac = 1'b1;
    tick(400);
    check("t1_ldac_A", reg_a(), 'hCAB);
    check("t1_settle_len", low_seen - l0, 225);
    check("t1_settled", int'(settled), 1);

    vecs[0] = '{32'h9FFC,  16, 4, 1, 0, 1, 'hCAB, 'hBFF};
    vecs[1] = '{32'h1004,  16, 4, 1, 0, 0, 'h801, 'hBFF};
    vecs[2] = '{32'h1004,  15, 4, 0, 1, 0, 'h801, 'hBFF};
    vecs[3] = '{32'h1FFFF, 17, 4, 0, 1, 0, 'h801, 'hBFF};
    vecs[4] = '{32'h0,      0, 4, 0, 1, 0, 'h801, 'hBFF};
    vecs[5] = '{32'hA5A5,  16, 3, 1, 0, 1, 'h801, 'h569};
    dac_ldac = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d0 = done_seen;
      e0 = err_seen;
      send_frame(vecs[i].word, vecs[i].nbits, vecs[i].ph);
      check($sformatf("vec%0d_done", i), done_seen - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_err", i), err_seen - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_chan", i), int'(frame_chan), vecs[i].exp_chan);
      check($sformatf("vec%0d_A", i), reg_a(), vecs[i].exp_a);
      check($sformatf("vec%0d_B", i), reg_b(), vecs[i].exp_b);
    end

    // Latency: raw csn rise sampled at edge N, frame_done visible only after edge N+3.
    send_bits(32'h32AC, 16, 3);
    d0 = done_seen;
    dac_csn = 1'b1;
    tick(1); check("lat_s0", int'(frame_done), 0);
    tick(1); check("lat_s1", int'(frame_done), 0);
    tick(1); check("lat_s2", int'(frame_done), 0);
    tick(1); check("lat_s3", int'(frame_done), 1);
    tick(1); check("lat_s4", int'(frame_done), 0);
    tick(4);
    check("lat_once", done_seen - d0, 1);
    check("lat_A", reg_a(), 'hCAB);

    // Settling: identical rewrite keeps settled, a new value restarts it.
    tick(300);
    l0 = low_seen;
    send_frame(32'h32AC, 16, 4);
    tick(400);
    check("settle_same", low_seen - l0, 0);
    l0 = low_seen;
    send_frame(32'h32B0, 16, 4);
    tick(400);
    check("settle_diff", low_seen - l0, 225);
    check("settle_diff_A", reg_a(), 'hCAC);

    // Reset in the middle of a frame, csn released together with reset.
    dac_ldac = 1'b1;
    send_bits(32'h9FFC, 8, 4);
    d0 = done_seen;
    e0 = err_seen;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    dac_csn = 1'b1;
    tick(10);
    check("mid_rst_done", done_seen - d0, 0);
    check("mid_rst_err", err_seen - e0, 0);
    check("mid_rst_A", reg_a(), 'h400);
    check("mid_rst_B", reg_b(), 'h400);
    check("mid_rst_chan", int'(frame_chan), 0);
    check("mid_rst_settled", int'(settled), 1);
    dac_ldac = 1'b0;
    d0 = done_seen;
    send_frame(32'h32AC, 16, 4);
    dac_ldac = 1'b1;
    check("post_rst_done", done_seen - d0, 1);
    check("post_rst_A", reg_a(), 'hCAB);

    // Randomized frames against the reference model.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    in_m[0] = 'h400; in_m[1] = 'h400;
    out_m[0] = 'h400; out_m[1] = 'h400;
    last_chan = 0;
    for (int it = 0; it < 40; it++) begin
      w = 32'($urandom_range(0, 65535));
      r = int'($urandom_range(0, 9));
      n = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      if (n == 17) w = w | (32'($urandom_range(0, 1)) << 16);
      mode = int'($urandom_range(0, 2));
      ph = int'($urandom_range(3, 5));
      d0 = done_seen;
      e0 = err_seen;
      if (mode == 2) dac_ldac = 1'b0;
      send_frame(w, n, ph);
      if (mode == 1) begin
        dac_ldac = 1'b0;
        tick(4);
      end
      dac_ldac = 1'b1;
      tick(4);
      if (n == 16) begin
        ch  = int'((w >> 15) & 1);
        val = int'((((w >> 12) & 1) << 11) | (((w >> 13) & 1) << 10) | ((w >> 2) & 1023));
        in_m[ch] = val;
        last_chan = ch;
      end
      if (mode != 0) begin
        out_m[0] = in_m[0];
        out_m[1] = in_m[1];
      end
      check($sformatf("rnd%0d_done", it), done_seen - d0, (n == 16) ? 1 : 0);
      check($sformatf("rnd%0d_err", it), err_seen - e0, (n == 16) ? 0 : 1);
      check($sformatf("rnd%0d_chan", it), int'(frame_chan), last_chan);
      check($sformatf("rnd%0d_A", it), reg_a(), out_m[0]);
      check($sformatf("rnd%0d_B", it), reg_b(), out_m[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
